wrb_arbiter: RTL and testbench
==============================

// Module: wrb_arbiter
// PURPOSE
//  Multi-source writeback arbiter between the result producers (LSU pipe, CSR,
//  divider, future M/F units) and the single register-file write port.
//  Source 0 is the in-order pipe: it is never stalled and never buffered.
//  Sources 1..NUM_SRC-1 are long-latency units. Each has its own result FIFO and
//  shares leftover write-port slots round-robin, with anti-starvation hold.
//  Output is registered and drives the ID feedback, EXE feedback and forwarding paths.
// PARAMETERS
//  XLEN        32  register data width
//  NUM_SRC     4   number of result sources, >=2; index 0 = in-order pipe
//  DEPTH       2   per-source result FIFO depth for sources 1..NUM_SRC-1, >=1
//  ADDR_W      5   destination register address width
//  STARVE_LIM  8   consecutive preempted cycles of a full FIFO before hold_o
// PORTS
//  clk              in   1                 clock, rising edge
//  rst              in   1                 asynchronous reset, active-high
//  src_valid_i      in   NUM_SRC           result valid per source
//  src_ready_o      out  NUM_SRC           accept per source; [0] tied 1, [i] = !full[i]
//  src_rd_addr_i    in   NUM_SRC x ADDR_W  destination register per source
//  src_rd_data_i    in   NUM_SRC x XLEN    result data per source
//  flush_i          in   1                 discard all buffered results, sources 1..N-1
//  hold_o           out  1                 registered; upstream keeps src_valid_i[0]=0 next cycle
//  wrb_rd_wr_req_o  out  1                 registered regfile write enable
//  wrb_rd_addr_o    out  ADDR_W            registered write address
//  wrb_rd_data_o    out  XLEN              registered write data
//  wrb_src_o        out  $clog2(NUM_SRC)   index of the source that owns the current write
// BEHAVIOUR
//  - Reset (async, rst=1): all FIFOs empty; rr pointer = 1; starve counter = 0;
//    hold_o=0. wrb_* outputs are all 0. src_ready_o = all 1s, because it is derived
//    combinationally from the empty FIFOs.
//  - Push: source i>0 is enqueued when src_valid_i[i] && src_ready_o[i].
//    No pass-through: a result is visible to arbitration no earlier than the cycle
//    after its push.
//  - Grant, per cycle:
//    - If src_valid_i[0]=1, source 0 is granted.
//    - Otherwise the first non-empty FIFO at or after the rr pointer is granted
//      (cyclic over 1..NUM_SRC-1) and popped. The rr pointer then moves to
//      granted+1, wrapping NUM_SRC-1 -> 1.
//    - If nothing is valid, no grant is made and the rr pointer is unchanged.
//  - Latency: a grant in cycle N appears on wrb_* in cycle N+1.
//    With no grant, wrb_rd_wr_req_o=0 and addr/data hold their previous values.
//  - rd_addr==0: the entry is granted and popped normally, but wrb_rd_wr_req_o stays 0.
//  - Same-cycle push and pop on one FIFO: both take effect and the count is unchanged.
//    A full FIFO cannot be pushed.
//  - Starvation:
//    - The counter increments each cycle in which some FIFO is full and source 0
//      is granted. It clears on any FIFO grant or on flush_i.
//    - When counter==STARVE_LIM-1 and it increments, hold_o=1 for the next cycle
//      only, and the counter clears.
//    - During a hold cycle source 0 must be idle. If it is valid anyway, source 0
//      still wins; the bench flags this as a protocol violation.
//  - flush_i: all FIFO counts go to 0 at the next edge, and a same-cycle push is
//    dropped. A same-cycle FIFO grant still completes, because the output register
//    is already loaded. Source 0 is unaffected.
//  - Mid-operation reset: contents are lost immediately and all outputs go to
//    their reset values.
//  - Widths: FIFO count is $clog2(DEPTH+1) bits. The rr pointer is $clog2(NUM_SRC)
//    bits and never takes the value 0.
// STRUCTURE
//  - Shared package (m_ext_defs.svh):
//    - type_wrb_req_s {rd_addr, rd_data}
//    - localparam WRB_SRC_PIPE=0
//    - type_wrb2arb_s for the registered output bundle
//  - Sub-module wrb_fifo (DEPTH, type_wrb_req_s payload, full/empty/push/pop/flush),
//    instantiated in a generate loop for sources 1..NUM_SRC-1.
//  - Arbiter, starve counter and output register are in the top level.
// TESTING
//  1. Reset:
//     - Stimulus: rst pulse mid-stream with 2 entries buffered in src1.
//     - Required: wrb_rd_wr_req_o=0, src_ready_o=4'b1111 and hold_o=0 immediately;
//       no stale write appears after reset is released.
//  2. Pipe priority:
//     - Stimulus: src0 addr=5 data=0xA5 and src2 push addr=7 data=0x77 in cycle 0.
//     - Required: cycle 1 writes x5=0xA5 (src 0); cycle 2 writes x7=0x77 (src 2).
//  3. Round-robin:
//     - Stimulus: src1, src2, src3 each hold 1 entry, src0 idle, rr=1.
//     - Required: grants are 1, 2, 3 in consecutive cycles. A new src1 entry
//       arriving afterwards is granted before src2's next entry.
//  4. Full/back-pressure:
//     - Stimulus: push 3 results to src1 with DEPTH=2 while src0 is busy.
//     - Required: src_ready_o[1]=0 after 2 pushes; the third is held upstream
//       until one entry drains.
//  5. Starvation:
//     - Stimulus: src1 full, src0 valid for 8 consecutive cycles.
//     - Required: hold_o=1 in cycle 9; with src0 idle that cycle, src1 is written
//       in cycle 10.
//  6. x0 and flush:
//     - x0 case: src2 entry with addr=0 is popped, wrb_rd_wr_req_o stays 0.
//     - Flush case: flush_i with src1 and src3 non-empty plus a same-cycle src3 push.
//     - Required: all FIFOs empty and no writes from sources 1..3 afterwards.

Source files
------------

// File: rtl/wrb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
// The source count and data widths are fixed here because the payload structs depend on them.
package wrb_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int NUM_SRC      = 4;
    localparam int ADDR_W       = 5;
    localparam int SRC_W        = $clog2(NUM_SRC);
    localparam int WRB_SRC_PIPE = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]   rd_data;
    } type_wrb_req_s;

    typedef struct packed {
        logic              wr_req;
        logic [ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]   rd_data;
        logic [SRC_W-1:0]  src;
    } type_wrb2arb_s;

    // Round-robin successor over the buffered sources 1..NUM_SRC-1 (0 is never produced).
    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] gnt);
        if (gnt == SRC_W'(NUM_SRC - 1)) begin
            return SRC_W'(1);
        end
        return gnt + SRC_W'(1);
    endfunction

endpackage

// File: rtl/wrb_arbiter_if.sv
// Result-source and register-file-write bundle of the writeback arbiter.
// slave = arbiter side, master = producer/regfile side.
interface wrb_arbiter_if;
    import wrb_arbiter_pkg::*;

    logic [NUM_SRC-1:0]             src_valid_i;
    logic [NUM_SRC-1:0]             src_ready_o;
    logic [NUM_SRC-1:0][ADDR_W-1:0] src_rd_addr_i;
    logic [NUM_SRC-1:0][XLEN-1:0]   src_rd_data_i;
    logic                           flush_i;
    logic                           hold_o;
    logic                           wrb_rd_wr_req_o;
    logic [ADDR_W-1:0]              wrb_rd_addr_o;
    logic [XLEN-1:0]                wrb_rd_data_o;
    logic [SRC_W-1:0]               wrb_src_o;

    modport slave (
        input  src_valid_i, src_rd_addr_i, src_rd_data_i, flush_i,
        output src_ready_o, hold_o, wrb_rd_wr_req_o, wrb_rd_addr_o, wrb_rd_data_o, wrb_src_o
    );

    modport master (
        output src_valid_i, src_rd_addr_i, src_rd_data_i, flush_i,
        input  src_ready_o, hold_o, wrb_rd_wr_req_o, wrb_rd_addr_o, wrb_rd_data_o, wrb_src_o
    );

endinterface

// File: rtl/wrb_arbiter_fifo.sv
// Per-source result FIFO; head is registered storage, so a push is visible the cycle after.
// Push is ignored when full or flushing; flush empties the FIFO at the next edge.
module wrb_arbiter_fifo
    import wrb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  type_wrb_req_s i_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output type_wrb_req_s o_dat,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    type_wrb_req_s    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_dat   = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

endmodule

// File: rtl/wrb_arbiter.sv
// Writeback arbiter: source 0 (in-order pipe) always wins, buffered sources share leftover slots
// round-robin; one-cycle registered output; hold_o throttles the pipe when a full FIFO starves.
module wrb_arbiter
    import wrb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic               clk,
    input  logic               rst,
    wrb_arbiter_if.slave       wrb_bus
);

    localparam int STV_W = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;

    type_wrb_req_s      w_head [NUM_SRC];
    type_wrb_req_s      w_sel;
    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic               w_gnt_vld;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [SRC_W-1:0]   w_cand;
    int                 w_sum;
    logic               w_fifo_gnt;
    logic               w_starve_inc;

    logic [SRC_W-1:0]   r_rr;
    logic [STV_W-1:0]   r_starve;
    logic               r_hold;
    type_wrb2arb_s      r_out;

    // Slot 0 models the pipe as an unbuffered, never-full "FIFO" so the grant mux is uniform.
    assign w_head[WRB_SRC_PIPE]  = {wrb_bus.src_rd_addr_i[WRB_SRC_PIPE], wrb_bus.src_rd_data_i[WRB_SRC_PIPE]};
    assign w_full[WRB_SRC_PIPE]  = 1'b0;
    assign w_empty[WRB_SRC_PIPE] = !wrb_bus.src_valid_i[WRB_SRC_PIPE];

    for (genvar gi = 1; gi < NUM_SRC; gi++) begin : g_fifo
        wrb_arbiter_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (wrb_bus.src_valid_i[gi] && !w_full[gi] && !wrb_bus.flush_i),
            .i_dat   ({wrb_bus.src_rd_addr_i[gi], wrb_bus.src_rd_data_i[gi]}),
            .i_pop   (w_gnt_vld && (w_gnt_idx == SRC_W'(gi))),
            .i_flush (wrb_bus.flush_i),
            .o_dat   (w_head[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi])
        );
    end

    assign wrb_bus.src_ready_o = ~w_full;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = 0;
        w_cand    = '0;
        if (wrb_bus.src_valid_i[WRB_SRC_PIPE]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SRC_W'(WRB_SRC_PIPE);
        end else begin
            // Scan rr, rr+1, ... wrapping within 1..NUM_SRC-1.
            for (int k = 0; k < NUM_SRC - 1; k++) begin
                w_sum = int'(r_rr) + k;
                if (w_sum >= NUM_SRC) begin
                    w_sum = w_sum - (NUM_SRC - 1);
                end
                w_cand = SRC_W'(w_sum);
                if (!w_gnt_vld && !w_empty[w_cand]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
        end
    end

    assign w_sel        = w_head[w_gnt_idx];
    assign w_fifo_gnt   = w_gnt_vld && (w_gnt_idx != SRC_W'(WRB_SRC_PIPE));
    assign w_starve_inc = (|w_full) && wrb_bus.src_valid_i[WRB_SRC_PIPE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= SRC_W'(1);
        end else if (w_fifo_gnt) begin
            r_rr <= rr_next(w_gnt_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else if (wrb_bus.flush_i || w_fifo_gnt) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else if (w_starve_inc) begin
            if (r_starve == STV_W'(STARVE_LIM - 1)) begin
                r_starve <= '0;
                r_hold   <= 1'b1;
            end else begin
                r_starve <= r_starve + STV_W'(1);
                r_hold   <= 1'b0;
            end
        end else begin
            r_hold <= 1'b0;
        end
    end

    // x0 writes are consumed but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out.wr_req <= w_gnt_vld && (w_sel.rd_addr != '0);
            if (w_gnt_vld) begin
                r_out.rd_addr <= w_sel.rd_addr;
                r_out.rd_data <= w_sel.rd_data;
                r_out.src     <= w_gnt_idx;
            end
        end
    end

    assign wrb_bus.hold_o          = r_hold;
    assign wrb_bus.wrb_rd_wr_req_o = r_out.wr_req;
    assign wrb_bus.wrb_rd_addr_o   = r_out.rd_addr;
    assign wrb_bus.wrb_rd_data_o   = r_out.rd_data;
    assign wrb_bus.wrb_src_o       = r_out.src;

endmodule

// File: tb/tb_wrb_arbiter.sv
// Bench for wrb_arbiter: directed vector table, hand-written reset/starvation sequences,
// then random traffic checked against a queue-based reference model.
module tb_wrb_arbiter;
    import wrb_arbiter_pkg::*;

    localparam int DEPTH      = 2;
    localparam int STARVE_LIM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wrb_arbiter_if bus();

    wrb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wrb_bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0][4:0] a, input logic [3:0][31:0] d, input logic fl);
        bus.src_valid_i   = v;
        bus.src_rd_addr_i = a;
        bus.src_rd_data_i = d;
        bus.flush_i       = fl;
    endtask

    task automatic drive01(input logic [3:0] v, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
        logic [3:0][4:0]  a;
        logic [3:0][31:0] d;
        a = '0;
        d = '0;
        a[0] = a0; d[0] = d0;
        a[1] = a1; d[1] = d1;
        drive(v, a, d, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] out_ad();
        return 64'({bus.wrb_rd_addr_o, bus.wrb_rd_data_o, bus.wrb_src_o});
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]       v;
        logic [3:0][4:0]  a;
        logic [3:0][31:0] d;
        logic             fl;
        logic             e_req;
        logic [4:0]       e_addr;
        logic [31:0]      e_data;
        logic [1:0]       e_src;
        logic [3:0]       e_rdy;
        logic             chk_ad;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [3:0] v,
                                input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] a2, input logic [31:0] d2,
                                input logic [4:0] a3, input logic [31:0] d3,
                                input logic fl, input logic req, input logic [4:0] ea,
                                input logic [31:0] ed, input logic [1:0] es,
                                input logic [3:0] rdy, input logic chk);
        vec_t r;
        r.v = v;
        r.a[0] = a0; r.d[0] = d0; r.a[1] = a1; r.d[1] = d1;
        r.a[2] = a2; r.d[2] = d2; r.a[3] = a3; r.d[3] = d3;
        r.fl = fl; r.e_req = req; r.e_addr = ea; r.e_data = ed; r.e_src = es;
        r.e_rdy = rdy; r.chk_ad = chk;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq [NUM_SRC][$];
    int          m_rr;
    int          m_cnt;
    logic        m_hold;
    logic        m_req;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_src;

    task automatic model_reset();
        for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        m_rr = 1; m_cnt = 0; m_hold = 1'b0; m_req = 1'b0;
        m_addr = '0; m_data = '0; m_src = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently on the bus.
    task automatic model_edge();
        int g;
        bit anyfull;
        bit rdy [NUM_SRC];
        ent_t e;
        g = -1;
        anyfull = 1'b0;
        for (int i = 1; i < NUM_SRC; i++) begin
            rdy[i] = (mq[i].size() < DEPTH);
            if (!rdy[i]) anyfull = 1'b1;
        end
        if (bus.src_valid_i[0]) begin
            g = 0;
        end else begin
            for (int k = 0; k < NUM_SRC - 1; k++) begin
                int c;
                c = ((m_rr - 1 + k) % (NUM_SRC - 1)) + 1;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
        end
        m_req = 1'b0;
        if (g == 0) begin
            m_addr = bus.src_rd_addr_i[0];
            m_data = bus.src_rd_data_i[0];
            m_src  = 2'd0;
            m_req  = (m_addr != 0);
        end else if (g > 0) begin
            e = mq[g].pop_front();
            m_addr = e.a;
            m_data = e.d;
            m_src  = 2'(g);
            m_req  = (e.a != 0);
            m_rr   = (g % (NUM_SRC - 1)) + 1;
        end
        for (int i = 1; i < NUM_SRC; i++) begin
            if (bus.src_valid_i[i] && rdy[i] && !bus.flush_i)
                mq[i].push_back(ent_t'{bus.src_rd_addr_i[i], bus.src_rd_data_i[i]});
        end
        if (bus.flush_i) begin
            for (int i = 1; i < NUM_SRC; i++) mq[i].delete();
        end
        if (bus.flush_i || g > 0) begin
            m_cnt = 0; m_hold = 1'b0;
        end else if (anyfull && g == 0) begin
            m_cnt++;
            m_hold = (m_cnt == STARVE_LIM);
            if (m_hold) m_cnt = 0;
        end else begin
            m_hold = 1'b0;
        end
    endtask

    function automatic logic [3:0] model_rdy();
        logic [3:0] r;
        r = 4'b0001;
        for (int i = 1; i < NUM_SRC; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    initial begin
        drive('0, '0, '0, 1'b0);

        // Table: pipe priority, round-robin, back-pressure, x0 and flush.
        tv.push_back(mk(4'b0101,  5,32'hA5,  0,0,      7,32'h77,  0,0,      0, 1,  5,32'hA5, 0, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 1,  7,32'h77, 2, 4'hF, 1));
        tv.push_back(mk(4'b1000,  0,0,       0,0,      0,0,       3,32'h33, 0, 0,  7,32'h77, 2, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 1,  3,32'h33, 3, 4'hF, 1));
        tv.push_back(mk(4'b1110,  0,0,      11,32'h11, 12,32'h12, 13,32'h13, 0, 0,  3,32'h33, 3, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 1, 11,32'h11, 1, 4'hF, 1));
        tv.push_back(mk(4'b0110,  0,0,      21,32'h21, 22,32'h22, 0,0,      0, 1, 12,32'h12, 2, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 1, 13,32'h13, 3, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 1, 21,32'h21, 1, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 1, 22,32'h22, 2, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 0, 22,32'h22, 2, 4'hF, 1));
        tv.push_back(mk(4'b0011,  1,32'h100,14,32'h141,0,0,       0,0,      0, 1,  1,32'h100,0, 4'hF, 1));
        tv.push_back(mk(4'b0011,  2,32'h200,15,32'h151,0,0,       0,0,      0, 1,  2,32'h200,0, 4'hD, 1));
        tv.push_back(mk(4'b0011,  3,32'h300,16,32'h161,0,0,       0,0,      0, 1,  3,32'h300,0, 4'hD, 1));
        tv.push_back(mk(4'b0010,  0,0,      16,32'h161,0,0,       0,0,      0, 1, 14,32'h141,1, 4'hF, 1));
        tv.push_back(mk(4'b0010,  0,0,      16,32'h161,0,0,       0,0,      0, 1, 15,32'h151,1, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 1, 16,32'h161,1, 4'hF, 1));
        tv.push_back(mk(4'b0100,  0,0,       0,0,      0,32'hDEAD,0,0,      0, 0, 16,32'h161,1, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 0,  0,0,      0, 4'hF, 0));
        tv.push_back(mk(4'b1010,  0,0,       8,32'h81, 0,0,       9,32'h91, 0, 0,  0,0,      0, 4'hF, 0));
        tv.push_back(mk(4'b1000,  0,0,       0,0,      0,0,      10,32'hA1, 1, 1,  9,32'h91, 3, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 0,  9,32'h91, 3, 4'hF, 1));
        tv.push_back(mk(4'b0000,  0,0,       0,0,      0,0,       0,0,      0, 0,  9,32'h91, 3, 4'hF, 1));

        // Reset state.
        repeat (2) tick();
        check("reset wr_req", 64'(bus.wrb_rd_wr_req_o), 64'(0));
        check("reset addr/data/src", out_ad(), 64'(0));
        check("reset ready", 64'(bus.src_ready_o), 64'hF);
        check("reset hold", 64'(bus.hold_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[r]) begin
            drive(tv[r].v, tv[r].a, tv[r].d, tv[r].fl);
            tick();
            check($sformatf("vec%0d wr_req", r), 64'(bus.wrb_rd_wr_req_o), 64'(tv[r].e_req));
            check($sformatf("vec%0d ready", r), 64'(bus.src_ready_o), 64'(tv[r].e_rdy));
            check($sformatf("vec%0d hold", r), 64'(bus.hold_o), 64'(0));
            if (tv[r].chk_ad)
                check($sformatf("vec%0d addr/data/src", r), out_ad(),
                      64'({tv[r].e_addr, tv[r].e_data, tv[r].e_src}));
        end

        // Mid-stream reset with two entries buffered in src1.
        drive01(4'b0011, 5'd4, 32'h44, 5'd17, 32'h1701); tick();
        drive01(4'b0011, 5'd4, 32'h45, 5'd18, 32'h1801); tick();
        check("pre-reset ready", 64'(bus.src_ready_o), 64'hD);
        drive('0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async reset wr_req", 64'(bus.wrb_rd_wr_req_o), 64'(0));
        check("async reset ready", 64'(bus.src_ready_o), 64'hF);
        check("async reset hold", 64'(bus.hold_o), 64'(0));
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post-reset no stale write %0d", k), 64'(bus.wrb_rd_wr_req_o), 64'(0));
        end

        // Starvation: fill src1, keep the pipe busy, expect one hold cycle.
        drive01(4'b0011, 5'd6, 32'h600, 5'd20, 32'h2001); tick();
        drive01(4'b0011, 5'd6, 32'h600, 5'd21, 32'h2101); tick();
        check("starve src1 full", 64'(bus.src_ready_o), 64'hD);
        for (int k = 0; k < STARVE_LIM; k++) begin
            drive01(4'b0001, 5'd6, 32'h600, 5'd0, 32'h0);
            tick();
            check($sformatf("starve hold cycle %0d", k), 64'(bus.hold_o), 64'(k == STARVE_LIM - 1));
        end
        drive('0, '0, '0, 1'b0);
        tick();
        check("starve release wr_req", 64'(bus.wrb_rd_wr_req_o), 64'(1));
        check("starve release addr/data/src", out_ad(), 64'({5'd20, 32'h2001, 2'd1}));
        check("starve hold drops", 64'(bus.hold_o), 64'(0));
        tick();
        check("starve second entry", out_ad(), 64'({5'd21, 32'h2101, 2'd1}));

        // Random traffic against the reference model.
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0]       v;
            logic [3:0][4:0]  a;
            logic [3:0][31:0] d;
            logic             fl;
            bit               busy;
            busy = ((cyc / 200) % 2) == 1;
            v[0] = busy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            if (m_hold) v[0] = 1'b0;
            for (int i = 1; i < NUM_SRC; i++) v[i] = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NUM_SRC; i++) begin
                a[i] = 5'($urandom_range(0, 31));
                d[i] = $urandom;
            end
            fl = ($urandom_range(0, 63) == 0);
            drive(v, a, d, fl);
            model_edge();
            tick();
            check($sformatf("rand%0d wr_req", cyc), 64'(bus.wrb_rd_wr_req_o), 64'(m_req));
            check($sformatf("rand%0d hold", cyc), 64'(bus.hold_o), 64'(m_hold));
            check($sformatf("rand%0d ready", cyc), 64'(bus.src_ready_o), 64'(model_rdy()));
            if (m_req)
                check($sformatf("rand%0d addr/data/src", cyc), out_ad(), 64'({m_addr, m_data, m_src}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
